// File: rtl/clocks_pkg.sv
// ---------------------------------------------------------------------------
// clocks_pkg
// Shared definitions for the multi-phase CPU clock generator.
//   clk_state_e  : controller states (HALT is only reachable when the design
//                  is built with CLOCKS_STEP_EN defined)
//   MAX_NPHASE   : largest supported number of phase outputs
//   MIN_DIV      : smallest supported eclk count per phase slot
//   cnt_width()  : counter width helper, never narrower than one bit
//   params_legal(): elaboration-time parameter check used by the top
// ---------------------------------------------------------------------------
package clocks_pkg;

  typedef enum logic [1:0] {
    RESET_HOLD = 2'd0,
    RUN        = 2'd1,
    HALT       = 2'd2
  } clk_state_e;

  localparam int MAX_NPHASE = 8;
  localparam int MIN_DIV    = 2;

  // Bits needed to count 0..n-1, with a floor of one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic bit params_legal(input int nphase, input int div,
                                      input int gap, input int reset_cycles);
    return (nphase >= 1) && (nphase <= MAX_NPHASE) &&
           (div >= MIN_DIV) &&
           (gap >= 0) && (gap <= div - 1) &&
           (reset_cycles >= 1);
  endfunction

endpackage

// File: rtl/clk_slot_counter.sv
// ---------------------------------------------------------------------------
// clk_slot_counter
// Position within the CPU cycle as (slot, eclk-within-slot). Advances one
// eclk per clock and wraps after slot NPHASE-1.
//   clk       : eclk
//   rst_n     : synchronous active-low reset, clears both counters
//   hold      : keep the current position
//   clear     : force position to (0,0); wins over hold
//   slot_d    : next slot value (what the flops load on this edge)
//   sub_d     : next eclk-within-slot value
//   last_d    : next position is the last eclk of the CPU cycle
//   cycle_end : current position is the last eclk of the CPU cycle
// ---------------------------------------------------------------------------
module clk_slot_counter
  import clocks_pkg::*;
#(
  parameter int NPHASE = 2,
  parameter int DIV    = 4,
  localparam int SLOT_W = cnt_width(NPHASE),
  localparam int SUB_W  = cnt_width(DIV)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hold,
  input  logic              clear,
  output logic [SLOT_W-1:0] slot_d,
  output logic [SUB_W-1:0]  sub_d,
  output logic              last_d,
  output logic              cycle_end
);

  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NPHASE - 1);
  localparam logic [SUB_W-1:0]  LAST_SUB  = SUB_W'(DIV - 1);

  logic [SLOT_W-1:0] slot_q;
  logic [SUB_W-1:0]  sub_q;

  always_comb begin
    slot_d = slot_q;
    sub_d  = sub_q;
    if (clear) begin
      slot_d = '0;
      sub_d  = '0;
    end else if (!hold) begin
      if (sub_q == LAST_SUB) begin
        sub_d  = '0;
        slot_d = (slot_q == LAST_SLOT) ? '0 : slot_q + 1'b1;
      end else begin
        sub_d = sub_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_q <= '0;
      sub_q  <= '0;
    end else begin
      slot_q <= slot_d;
      sub_q  <= sub_d;
    end
  end

  assign cycle_end = (slot_q == LAST_SLOT) && (sub_q == LAST_SUB);
  assign last_d    = (slot_d == LAST_SLOT) && (sub_d == LAST_SUB);

endmodule

// File: rtl/clocks_multi.sv
// ---------------------------------------------------------------------------
// clocks_multi
// Non-overlapping multi-phase CPU clock generator with reset sequencing.
// A CPU cycle is NPHASE slots of DIV eclk; phi[k] is high for the first
// DIV-GAP eclk of slot k. _reset is held low for RESET_CYCLES CPU cycles
// after _ereset is released.
//   eclk      : sole clock
//   _ereset   : synchronous active-low reset
//   phi       : registered phase clocks, phi[0] is the CPU clock
//   _reset    : registered active-low CPU reset
//   cycle_cnt : completed CPU cycles since reset (wraps)
// Build option CLOCKS_STEP_EN adds run/step/halted and the HALT state:
//   run       : free-run enable, sampled at cycle end or while halted
//   step      : single-cycle request, sampled while halted
//   halted    : high in every eclk the controller is in HALT
// ---------------------------------------------------------------------------
module clocks_multi
  import clocks_pkg::*;
#(
  parameter int NPHASE       = 2,
  parameter int DIV          = 4,
  parameter int GAP          = 1,
  parameter int RESET_CYCLES = 3
) (
  input  logic              eclk,
  input  logic              _ereset,
  output logic [NPHASE-1:0] phi,
  output logic              _reset,
  output logic [31:0]       cycle_cnt
`ifdef CLOCKS_STEP_EN
  ,
  output logic              halted,
  input  logic              run,
  input  logic              step
`endif
);

  localparam int SLOT_W = cnt_width(NPHASE);
  localparam int SUB_W  = cnt_width(DIV);
  localparam int HC_W   = cnt_width(RESET_CYCLES);

  if (!params_legal(NPHASE, DIV, GAP, RESET_CYCLES)) begin : g_illegal_params
    $error("clocks_multi: illegal NPHASE/DIV/GAP/RESET_CYCLES combination");
  end

  clk_state_e        state_q, state_d;
  logic              active_q, active_d;       // a CPU cycle is in progress
  logic              rst_out_q, rst_out_d;
  logic [HC_W-1:0]   hold_cnt_q, hold_cnt_d;   // RESET_HOLD cycles finished
  logic [31:0]       cycle_cnt_q, cycle_cnt_d;
  logic [NPHASE-1:0] phi_q, phi_d;
`ifdef CLOCKS_STEP_EN
  logic              halted_q, halted_d;
`endif

  logic              ctr_hold, ctr_clear;
  logic [SLOT_W-1:0] slot_nx;
  logic [SUB_W-1:0]  sub_nx;
  logic              last_nx;
  logic              cycle_end;

  // While idle the counter sits at (0,0); on the edge that starts a cycle
  // it must stay there so that edge is the first eclk of slot 0. Leaving
  // the active state parks it back at (0,0).
  assign ctr_hold  = !active_q;
  assign ctr_clear = !active_d;

  clk_slot_counter #(
    .NPHASE (NPHASE),
    .DIV    (DIV)
  ) u_slot_counter (
    .clk       (eclk),
    .rst_n     (_ereset),
    .hold      (ctr_hold),
    .clear     (ctr_clear),
    .slot_d    (slot_nx),
    .sub_d     (sub_nx),
    .last_d    (last_nx),
    .cycle_end (cycle_end)
  );

  always_comb begin
    state_d    = state_q;
    active_d   = active_q;
    rst_out_d  = rst_out_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      RESET_HOLD: begin
        active_d = 1'b1;
        if (cycle_end) begin
          // The edge after the last eclk of cycle RESET_CYCLES-1 starts
          // cycle RESET_CYCLES, which is the first cycle with _reset high.
          if (hold_cnt_q == HC_W'(RESET_CYCLES - 1)) begin
            state_d   = RUN;
            rst_out_d = 1'b1;
          end else begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
        end
      end
      RUN: begin
        active_d = 1'b1;
`ifdef CLOCKS_STEP_EN
        // A step-started cycle also runs in RUN; it returns to HALT here
        // because run is low, regardless of step.
        if (cycle_end && !run) begin
          state_d  = HALT;
          active_d = 1'b0;
        end
`endif
      end
`ifdef CLOCKS_STEP_EN
      HALT: begin
        if (run || step) begin
          state_d  = RUN;
          active_d = 1'b1;
        end
      end
`endif
      default: begin
        state_d  = RESET_HOLD;
        active_d = 1'b0;
      end
    endcase
`ifdef CLOCKS_STEP_EN
    halted_d = (state_d == HALT);
`endif
  end

  // Count the cycle on the edge that enters its last eclk.
  always_comb begin
    cycle_cnt_d = cycle_cnt_q;
    if (active_d && last_nx) begin
      cycle_cnt_d = cycle_cnt_q + 32'd1;
    end
  end

  // Phase decode from the counter's next position so phi is a flop that
  // changes on the same edge the slot starts.
  for (genvar gi = 0; gi < NPHASE; gi++) begin : g_phi
    assign phi_d[gi] = active_d && (slot_nx == SLOT_W'(gi)) &&
                       (int'(sub_nx) < (DIV - GAP));
  end

  always_ff @(posedge eclk) begin
    if (!_ereset) begin
      state_q     <= RESET_HOLD;
      active_q    <= 1'b0;
      rst_out_q   <= 1'b0;
      hold_cnt_q  <= '0;
      cycle_cnt_q <= '0;
      phi_q       <= '0;
`ifdef CLOCKS_STEP_EN
      halted_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      active_q    <= active_d;
      rst_out_q   <= rst_out_d;
      hold_cnt_q  <= hold_cnt_d;
      cycle_cnt_q <= cycle_cnt_d;
      phi_q       <= phi_d;
`ifdef CLOCKS_STEP_EN
      halted_q    <= halted_d;
`endif
    end
  end

  assign phi       = phi_q;
  assign _reset    = rst_out_q;
  assign cycle_cnt = cycle_cnt_q;
`ifdef CLOCKS_STEP_EN
  assign halted    = halted_q;
`endif

endmodule

// File: tb/tb_clocks_multi.sv
// ---------------------------------------------------------------------------
// tb_clocks_multi
// Two instances: A = NPHASE 2 / DIV 4 / GAP 1 / RESET_CYCLES 3,
//                B = NPHASE 4 / DIV 2 / GAP 0 / RESET_CYCLES 1.
// Stimulus pushes hand-computed expectations tagged with an absolute eclk
// edge number; a monitor pops and compares them 1 time unit after each
// rising edge. Phase non-overlap is checked on every edge.
// ---------------------------------------------------------------------------
module tb_clocks_multi;

  logic        eclk = 1'b0;
  logic        ereset_n;
  logic [1:0]  phi_a;
  logic        rst_a;
  logic [31:0] cnt_a;
  logic [3:0]  phi_b;
  logic        rst_b;
  logic [31:0] cnt_b;
  logic        hlt_a;
  logic        hlt_b;

  always #5 eclk = ~eclk;

`ifdef CLOCKS_STEP_EN
  logic halted_a, run_a, step_a;
  logic halted_b, run_b, step_b;
  assign hlt_a = halted_a;
  assign hlt_b = halted_b;
`else
  assign hlt_a = 1'b0;
  assign hlt_b = 1'b0;
`endif

  clocks_multi #(.NPHASE(2), .DIV(4), .GAP(1), .RESET_CYCLES(3)) dut_a (
    .eclk      (eclk),
    ._ereset   (ereset_n),
    .phi       (phi_a),
    ._reset    (rst_a),
    .cycle_cnt (cnt_a)
`ifdef CLOCKS_STEP_EN
    ,
    .halted    (halted_a),
    .run       (run_a),
    .step      (step_a)
`endif
  );

  clocks_multi #(.NPHASE(4), .DIV(2), .GAP(0), .RESET_CYCLES(1)) dut_b (
    .eclk      (eclk),
    ._ereset   (ereset_n),
    .phi       (phi_b),
    ._reset    (rst_b),
    .cycle_cnt (cnt_b)
`ifdef CLOCKS_STEP_EN
    ,
    .halted    (halted_b),
    .run       (run_b),
    .step      (step_b)
`endif
  );

  localparam logic [3:0] M_PHI = 4'b0001;
  localparam logic [3:0] M_RST = 4'b0010;
  localparam logic [3:0] M_CNT = 4'b0100;
  localparam logic [3:0] M_HLT = 4'b1000;
  localparam logic [3:0] M_ALL = 4'b0111;

  typedef struct {
    int unsigned edge_no;
    logic [7:0]  phi;
    logic        rst_n;
    logic [31:0] cnt;
    logic        halted;
    logic [3:0]  mask;
    string       name;
  } exp_t;

  exp_t        qa[$];
  exp_t        qb[$];
  int unsigned ecnt   = 0;
  int          errors = 0;
  int          checks = 0;

  always @(posedge eclk) ecnt++;

  task automatic pa(input int unsigned ed, input logic [7:0] p, input logic r,
                    input logic [31:0] c, input logic h, input logic [3:0] m,
                    input string nm);
    exp_t e;
    e.edge_no = ed; e.phi = p; e.rst_n = r; e.cnt = c; e.halted = h;
    e.mask = m; e.name = nm;
    qa.push_back(e);
  endtask

  task automatic pb(input int unsigned ed, input logic [7:0] p, input logic r,
                    input logic [31:0] c, input logic [3:0] m, input string nm);
    exp_t e;
    e.edge_no = ed; e.phi = p; e.rst_n = r; e.cnt = c; e.halted = 1'b0;
    e.mask = m; e.name = nm;
    qb.push_back(e);
  endtask

  task automatic check_item(input exp_t e, input string who,
                            input logic [7:0] p, input logic r,
                            input logic [31:0] c, input logic h);
    int bad;
    bad = 0;
    if (e.mask[0]) begin
      checks++;
      if (p !== e.phi) begin
        errors++; bad++;
        $display("FAIL %s %s edge %0d: phi got %b need %b", who, e.name, e.edge_no, p, e.phi);
      end
    end
    if (e.mask[1]) begin
      checks++;
      if (r !== e.rst_n) begin
        errors++; bad++;
        $display("FAIL %s %s edge %0d: _reset got %b need %b", who, e.name, e.edge_no, r, e.rst_n);
      end
    end
    if (e.mask[2]) begin
      checks++;
      if (c !== e.cnt) begin
        errors++; bad++;
        $display("FAIL %s %s edge %0d: cycle_cnt got %h need %h", who, e.name, e.edge_no, c, e.cnt);
      end
    end
    if (e.mask[3]) begin
      checks++;
      if (h !== e.halted) begin
        errors++; bad++;
        $display("FAIL %s %s edge %0d: halted got %b need %b", who, e.name, e.edge_no, h, e.halted);
      end
    end
    if (bad == 0)
      $display("ok   %s %s edge %0d: phi=%b _reset=%b cnt=%h halted=%b", who, e.name, e.edge_no, p, r, c, h);
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  always @(posedge eclk) begin
    exp_t e;
    #1;
    checks++;
    if (!$onehot0(phi_a)) begin
      errors++;
      $display("FAIL A overlap edge %0d: phi got %b need at most one bit high", ecnt, phi_a);
    end
    checks++;
    if (!$onehot0(phi_b)) begin
      errors++;
      $display("FAIL B overlap edge %0d: phi got %b need at most one bit high", ecnt, phi_b);
    end
    while (qa.size() > 0 && qa[0].edge_no <= ecnt) begin
      e = qa.pop_front();
      if (e.edge_no < ecnt) begin
        checks++; errors++;
        $display("FAIL A %s missed: edge %0d passed, now %0d", e.name, e.edge_no, ecnt);
      end else begin
        check_item(e, "A", {6'b0, phi_a}, rst_a, cnt_a, hlt_a);
      end
    end
    while (qb.size() > 0 && qb[0].edge_no <= ecnt) begin
      e = qb.pop_front();
      if (e.edge_no < ecnt) begin
        checks++; errors++;
        $display("FAIL B %s missed: edge %0d passed, now %0d", e.name, e.edge_no, ecnt);
      end else begin
        check_item(e, "B", {4'b0, phi_b}, rst_b, cnt_b, hlt_b);
      end
    end
  end

  // Returns on the falling edge that follows rising edge n.
  task automatic wait_edge(input int unsigned n);
    while (ecnt < n) @(negedge eclk);
  endtask

  // Expectations after a release whose last reset edge is b (E0).
  task automatic push_release_a(input int unsigned b);
    pa(b + 1,  8'b01, 1'b0, 32'd0, 1'b0, M_ALL, "slot0_start");
    pa(b + 3,  8'b01, 1'b0, 32'd0, 1'b0, M_PHI, "slot0_high_end");
    pa(b + 4,  8'b00, 1'b0, 32'd0, 1'b0, M_PHI, "slot0_gap");
    pa(b + 5,  8'b10, 1'b0, 32'd0, 1'b0, M_PHI, "slot1_start");
    pa(b + 7,  8'b10, 1'b0, 32'd0, 1'b0, M_PHI, "slot1_high_end");
    pa(b + 8,  8'b00, 1'b0, 32'd1, 1'b0, M_ALL, "cycle0_end");
    pa(b + 9,  8'b01, 1'b0, 32'd1, 1'b0, M_ALL, "cycle1_start");
    pa(b + 23, 8'b10, 1'b0, 32'd2, 1'b0, M_ALL, "cycle2_slot1");
    pa(b + 24, 8'b00, 1'b0, 32'd3, 1'b0, M_ALL, "cycle2_end");
    pa(b + 25, 8'b01, 1'b1, 32'd3, 1'b0, M_ALL, "reset_rise");
  endtask

  task automatic push_release_b(input int unsigned b);
    pb(b + 1,  8'b0001, 1'b0, 32'd0, M_ALL, "p0_first");
    pb(b + 2,  8'b0001, 1'b0, 32'd0, M_PHI, "p0_second");
    pb(b + 3,  8'b0010, 1'b0, 32'd0, M_PHI, "p1_abut");
    pb(b + 4,  8'b0010, 1'b0, 32'd0, M_PHI, "p1_second");
    pb(b + 5,  8'b0100, 1'b0, 32'd0, M_PHI, "p2");
    pb(b + 7,  8'b1000, 1'b0, 32'd0, M_PHI, "p3");
    pb(b + 8,  8'b1000, 1'b0, 32'd1, M_ALL, "cycle0_end");
    pb(b + 9,  8'b0001, 1'b1, 32'd1, M_ALL, "reset_rise");
    pb(b + 16, 8'b1000, 1'b1, 32'd2, M_ALL, "cycle1_end");
    pb(b + 17, 8'b0001, 1'b1, 32'd2, M_ALL, "cycle2_start");
  endtask

  initial begin
    int unsigned b;
    ereset_n = 1'b0;
`ifdef CLOCKS_STEP_EN
    run_a = 1'b1; step_a = 1'b0;
    run_b = 1'b1; step_b = 1'b0;
`endif
    repeat (2) @(negedge eclk);

    // Reset state, then release.
    pa(ecnt + 1, 8'b0, 1'b0, 32'd0, 1'b0, M_ALL, "reset_state");
    pb(ecnt + 1, 8'b0, 1'b0, 32'd0, M_ALL, "reset_state");
    @(negedge eclk);
    ereset_n = 1'b1;
    b = ecnt;
    push_release_a(b);
    push_release_b(b);
    pa(b + 44, 8'b00, 1'b1, 32'd5, 1'b0, M_ALL, "cycle5_slot0_gap");
    pa(b + 45, 8'b10, 1'b1, 32'd5, 1'b0, M_ALL, "cycle5_slot1");

    // Reset asserted while A is in slot 1.
    wait_edge(b + 45);
    ereset_n = 1'b0;
    pa(ecnt + 1, 8'b0, 1'b0, 32'd0, 1'b0, M_ALL, "reset_mid_cycle");
    pb(ecnt + 1, 8'b0, 1'b0, 32'd0, M_ALL, "reset_mid_cycle");
    @(negedge eclk);
    ereset_n = 1'b1;
    b = ecnt;
    push_release_a(b);
    push_release_b(b);

    // Counter wrap: preload 0xFFFFFFFE mid-cycle in A.
    wait_edge(b + 50);
    pa(b + 52, 8'b00, 1'b1, 32'hFFFF_FFFE, 1'b0, M_CNT, "preload");
    pa(b + 55, 8'b10, 1'b1, 32'hFFFF_FFFE, 1'b0, M_ALL, "preload_hold");
    pa(b + 56, 8'b00, 1'b1, 32'hFFFF_FFFF, 1'b0, M_ALL, "wrap_minus1");
    pa(b + 63, 8'b10, 1'b1, 32'hFFFF_FFFF, 1'b0, M_ALL, "wrap_pre");
    pa(b + 64, 8'b00, 1'b1, 32'h0000_0000, 1'b0, M_ALL, "wrap_zero");
    pa(b + 65, 8'b01, 1'b1, 32'h0000_0000, 1'b0, M_ALL, "wrap_next_cycle");
    force dut_a.cycle_cnt_d = 32'hFFFF_FFFE;
    wait_edge(b + 51);
    release dut_a.cycle_cnt_d;
    wait_edge(b + 66);

`ifdef CLOCKS_STEP_EN
    // Release with run low: A runs its first RUN cycle, then halts.
    ereset_n = 1'b0;
    run_a    = 1'b0;
    @(negedge eclk);
    @(negedge eclk);
    ereset_n = 1'b1;
    b = ecnt;
    push_release_b(b);
    pa(b + 1,  8'b01, 1'b0, 32'd0, 1'b0, M_ALL | M_HLT, "hr_start");
    pa(b + 24, 8'b00, 1'b0, 32'd3, 1'b0, M_ALL | M_HLT, "hr_hold_end");
    pa(b + 25, 8'b01, 1'b1, 32'd3, 1'b0, M_ALL | M_HLT, "hr_run_cycle");
    pa(b + 32, 8'b00, 1'b1, 32'd4, 1'b0, M_ALL | M_HLT, "hr_run_end");
    pa(b + 33, 8'b00, 1'b1, 32'd4, 1'b1, M_ALL | M_HLT, "halt_entry");
    pa(b + 37, 8'b00, 1'b1, 32'd4, 1'b1, M_ALL | M_HLT, "halt_idle");
    wait_edge(b + 37);
    pa(b + 38, 8'b01, 1'b1, 32'd4, 1'b0, M_ALL | M_HLT, "step_start");
    pa(b + 41, 8'b00, 1'b1, 32'd4, 1'b0, M_ALL | M_HLT, "step_gap");
    pa(b + 42, 8'b10, 1'b1, 32'd4, 1'b0, M_ALL | M_HLT, "step_slot1");
    pa(b + 45, 8'b00, 1'b1, 32'd5, 1'b0, M_ALL | M_HLT, "step_end");
    pa(b + 46, 8'b00, 1'b1, 32'd5, 1'b1, M_ALL | M_HLT, "step_rehalt");
    pa(b + 50, 8'b00, 1'b1, 32'd5, 1'b1, M_ALL | M_HLT, "step_stays_halted");
    step_a = 1'b1;
    @(negedge eclk);
    step_a = 1'b0;
    wait_edge(b + 51);
    pa(b + 52, 8'b01, 1'b1, 32'd5, 1'b0, M_ALL | M_HLT, "resume_start");
    pa(b + 59, 8'b00, 1'b1, 32'd6, 1'b0, M_ALL | M_HLT, "resume_end");
    pa(b + 60, 8'b01, 1'b1, 32'd6, 1'b0, M_ALL | M_HLT, "resume_continues");
    run_a = 1'b1;
    wait_edge(b + 62);
`endif

    repeat (3) @(negedge eclk);
    while (qa.size() > 0) begin
      checks++; errors++;
      $display("FAIL A %s never checked: edge %0d, now %0d", qa[0].name, qa[0].edge_no, ecnt);
      void'(qa.pop_front());
    end
    while (qb.size() > 0) begin
      checks++; errors++;
      $display("FAIL B %s never checked: edge %0d, now %0d", qb[0].name, qb[0].edge_no, ecnt);
      void'(qb.pop_front());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached at edge %0d, need completion", ecnt);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/clocks_multi.md
CLOCKS_MULTI -- requirements
Module: clocks_multi

Interface
REQ-001 Parameter NPHASE, 2, number of phase outputs per CPU cycle (legal 1..8).
REQ-002 Parameter DIV, 4, eclk cycles per phase slot (legal >=2).
REQ-003 Parameter GAP, 1, dead eclk cycles at the end of each slot for non-overlap (legal 0..DIV-1).
REQ-004 Parameter RESET_CYCLES, 3, CPU cycles _reset is held low after release (legal >=1).
REQ-005 eclk  in  1  sole clock; all state SHALL change on its rising edge.
REQ-006 _ereset  in  1  synchronous, active-low reset.
REQ-007 phi  out  NPHASE  registered phase clocks; phi[0] is the CPU clk.
REQ-008 _reset  out  1  active-low CPU reset, registered.
REQ-009 cycle_cnt  out  32  completed CPU cycles since reset.
REQ-010 halted  out  1  high while stopped in HALT (CLOCKS_STEP_EN only).
REQ-011 run  in  1  free-run enable (CLOCKS_STEP_EN only).
REQ-012 step  in  1  single-cycle request (CLOCKS_STEP_EN only).

Function
REQ-013 The CPU cycle SHALL be NPHASE slots of DIV eclk each, giving a period of NPHASE*DIV eclk.
REQ-014 phi[k] SHALL be high for the first DIV-GAP eclk of slot k and low otherwise; no two phi bits high in the same eclk cycle.
REQ-015 Outputs SHALL be flop outputs; a slot's first high eclk of phi[k] SHALL be the edge on which the slot starts.
REQ-016 States: RESET_HOLD, RUN, HALT (HALT only with CLOCKS_STEP_EN).
REQ-017 RESET_HOLD -> RUN on the edge starting CPU cycle index RESET_CYCLES (cycles counted from 0 after release); _reset rises on that same edge.
REQ-018 run/step SHALL be ignored in RESET_HOLD; clocks run freely there.
REQ-019 cycle_cnt SHALL increment by 1 on the last eclk of every CPU cycle, including RESET_HOLD cycles, wrapping 0xFFFFFFFF -> 0.
REQ-020 Cycle end is the last eclk of slot NPHASE-1; run and step SHALL be sampled only there, or on every eclk in HALT.
REQ-021 RUN, cycle end, run=0: go to HALT; phi all low; slot/phase counters held at 0; cycle_cnt still increments for the finished cycle.
REQ-022 HALT, run=1 or step=1: next eclk starts a full CPU cycle at phi[0]; run=1 returns to RUN.
REQ-023 A step-started cycle SHALL always complete; at its end run=0 returns to HALT, even if step is still high; a held step yields one cycle per period, with at least one HALT eclk between.
REQ-024 A stopped cycle is never truncated; run=0 mid-cycle takes effect only at cycle end.
REQ-025 halted SHALL be high exactly in the eclk cycles the state is HALT.

Reset
REQ-026 _ereset low on an edge SHALL give: phi=0, _reset=0, cycle_cnt=0, halted=0, counters=0, state RESET_HOLD, regardless of current state or slot.
REQ-027 Reset mid-cycle SHALL abort the cycle immediately with no partial phase after release.
REQ-028 First edge with _ereset high SHALL start slot 0 (phi[0] rises on that edge).

Configuration
REQ-029 Macro CLOCKS_STEP_EN: defined -> run, step, halted ports, HALT state and REQ-020..REQ-025 present.
REQ-030 Undefined -> those ports and HALT absent; block goes RESET_HOLD -> RUN and runs forever.

Structure
REQ-031 Package clocks_pkg SHALL hold the state enum and parameter-legality limits (max NPHASE=8, min DIV=2).
REQ-032 Sub-module clk_slot_counter SHALL hold the slot and phase counters, with hold/clear inputs and a cycle_end output.
REQ-033 Illegal parameters SHALL fail elaboration.

Verification
REQ-034 NPHASE=2, DIV=4, GAP=1, release at edge E0: phi[0] high E1..E3, low E4; phi[1] high E5..E7, low E8; period 8.
REQ-035 Same config, RESET_CYCLES=3: _reset rises at E25; cycle_cnt=3 after E24; phi never overlaps.
REQ-036 CLOCKS_STEP_EN, run=0 after reset release: HALT from E33; one-eclk step pulse -> exactly 8 eclk of phi activity, halted low 8 eclk, cycle_cnt +1.
REQ-037 _ereset low during slot 1 of a running cycle: next eclk phi=0, _reset=0, cycle_cnt=0; release restarts at phi[0].
REQ-038 Preload cycle_cnt near wrap (force 0xFFFFFFFE): two cycles later reads 0x00000000.
REQ-039 NPHASE=4, DIV=2, GAP=0: phi bits high in rotation 2 eclk each, period 8, adjacent phases abut without overlap.
